// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller: state encoding, BCD limits, timer width.
// Declarations only; no latency or flow control of its own.
package alarm_pkg;

  localparam int CNT_W = 9;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZING = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] hr_t;
    logic [3:0] hr_o;
    logic [3:0] mn_t;
    logic [3:0] mn_o;
  } bcd_time_t;

  localparam logic [3:0] HR_T_MAX    = 4'd2;
  localparam logic [3:0] HR_O_MAX    = 4'd9;
  localparam logic [3:0] HR_O_MAX_20 = 4'd3;
  localparam logic [3:0] MN_T_MAX    = 4'd5;
  localparam logic [3:0] MN_O_MAX    = 4'd9;

  // Legal 24h wall-clock time: 00:00 .. 23:59 with every digit in BCD range.
  function automatic logic bcd_time_ok(input bcd_time_t t);
    logic hr_ok;
    if (t.hr_t < HR_T_MAX)
      hr_ok = (t.hr_o <= HR_O_MAX);
    else
      hr_ok = (t.hr_t == HR_T_MAX) && (t.hr_o <= HR_O_MAX_20);
    return hr_ok && (t.mn_t <= MN_T_MAX) && (t.mn_o <= MN_O_MAX);
  endfunction

endpackage

// File: rtl/alarm_if.sv
// Time/control inputs and ring/status outputs of the alarm controller.
// Levels and single-cycle pulses only; no handshake, the controller never stalls.
interface alarm_if;
  import alarm_pkg::*;

  logic       sec_tick;
  logic [3:0] hr_t;
  logic [3:0] hr_o;
  logic [3:0] mn_t;
  logic [3:0] mn_o;
  logic       alarm_en;
  logic       set_load;
  logic [3:0] set_hr_t;
  logic [3:0] set_hr_o;
  logic [3:0] set_mn_t;
  logic [3:0] set_mn_o;
  logic       stop;
  logic       snooze;
  logic       ring;
  logic       armed;
  state_t     state_o;
  logic [1:0] snooze_left;
  logic       set_err;

  modport master (
    output sec_tick, hr_t, hr_o, mn_t, mn_o, alarm_en, set_load,
           set_hr_t, set_hr_o, set_mn_t, set_mn_o, stop, snooze,
    input  ring, armed, state_o, snooze_left, set_err
  );

  modport slave (
    input  sec_tick, hr_t, hr_o, mn_t, mn_o, alarm_en, set_load,
           set_hr_t, set_hr_o, set_mn_t, set_mn_o, stop, snooze,
    output ring, armed, state_o, snooze_left, set_err
  );

endinterface

// File: rtl/alarm_sec_timer.sv
// Saturating second counter with clear/enable and a terminal-count compare on the next value.
// hit is combinational in the enable cycle; no backpressure, clr beats en.
module alarm_sec_timer
  import alarm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             hit
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  assign hit     = en && (cnt_inc == term);

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt_inc;
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: stored alarm time, edge-triggered match, arm/ring/snooze FSM with timed ring and snooze.
// Outputs registered, 1 cycle after the causing input; no backpressure, every input is acted on.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned MAX_SNOOZE  = 3
) (
  input  logic    clk,
  input  logic    reset,
  alarm_if.slave  bus
);

  localparam logic [CNT_W-1:0] RING_TERM   = CNT_W'(RING_SECS);
  localparam logic [CNT_W-1:0] SNOOZE_TERM = CNT_W'(SNOOZE_SECS);
  localparam logic [1:0]       SNOOZE_MAX  = 2'(MAX_SNOOZE);

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       used;
  logic [1:0]       used_nxt;
  bcd_time_t        alarm_q;
  bcd_time_t        now;
  bcd_time_t        set_val;
  logic             match;
  logic             match_q;
  logic             trigger;
  logic             set_ok;
  logic             load;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_hit;
  logic [CNT_W-1:0] cnt_term;
  logic             ring_q;
  logic             set_err_q;
  logic             set_err_nxt;
  logic [1:0]       snooze_left_q;

  assign now     = {bus.hr_t, bus.hr_o, bus.mn_t, bus.mn_o};
  assign set_val = {bus.set_hr_t, bus.set_hr_o, bus.set_mn_t, bus.set_mn_o};
  assign set_ok  = bcd_time_ok(set_val);
  assign match   = (now == alarm_q);
  // Firing needs a rising match so arming or stopping inside the alarm minute stays quiet.
  assign trigger = match && !match_q;

  assign cnt_term = (state == SNOOZING) ? SNOOZE_TERM : RING_TERM;

  alarm_sec_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .term  (cnt_term),
    .hit   (cnt_hit)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= DISARMED;
    else
      state <= state_nxt;
  end

  // One action per cycle, taken in strict priority order.
  always_comb begin
    state_nxt   = state;
    used_nxt    = used;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    load        = 1'b0;
    set_err_nxt = 1'b0;
    if (!bus.alarm_en) begin
      state_nxt = DISARMED;
      cnt_clr   = 1'b1;
      used_nxt  = '0;
    end else if (bus.set_load && set_ok) begin
      load = 1'b1;
      if (state != DISARMED) begin
        state_nxt = ARMED;
        cnt_clr   = 1'b1;
        used_nxt  = '0;
      end
    end else if (bus.set_load) begin
      set_err_nxt = 1'b1;
    end else if (bus.stop && (state == RINGING || state == SNOOZING)) begin
      state_nxt = ARMED;
      cnt_clr   = 1'b1;
      used_nxt  = '0;
    end else if (bus.snooze && state == RINGING && used < SNOOZE_MAX) begin
      state_nxt = SNOOZING;
      used_nxt  = used + 2'd1;
      cnt_clr   = 1'b1;
    end else if (bus.sec_tick && state == RINGING) begin
      cnt_en = 1'b1;
      if (cnt_hit) begin
        state_nxt = ARMED;
        cnt_clr   = 1'b1;
        used_nxt  = '0;
      end
    end else if (bus.sec_tick && state == SNOOZING) begin
      cnt_en = 1'b1;
      if (cnt_hit) begin
        state_nxt = RINGING;
        cnt_clr   = 1'b1;
      end
    end else if (state == ARMED && trigger) begin
      state_nxt = RINGING;
      cnt_clr   = 1'b1;
      used_nxt  = '0;
    end else if (state == DISARMED) begin
      state_nxt = ARMED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      used          <= '0;
      alarm_q       <= '0;
      match_q       <= 1'b0;
      ring_q        <= 1'b0;
      set_err_q     <= 1'b0;
      snooze_left_q <= '0;
    end else begin
      used          <= used_nxt;
      match_q       <= match;
      ring_q        <= (state_nxt == RINGING);
      set_err_q     <= set_err_nxt;
      snooze_left_q <= SNOOZE_MAX - used_nxt;
      if (load)
        alarm_q <= set_val;
    end
  end

  assign bus.ring        = ring_q;
  assign bus.armed       = (state != DISARMED);
  assign bus.state_o     = state;
  assign bus.snooze_left = snooze_left_q;
  assign bus.set_err     = set_err_q;

endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Alarm controller downstream of the clock's cascaded modulo counters: it consumes the seconds-stage carry pulse and the BCD hour/minute digits those counters produce. It holds a programmable alarm time, detects the match, and drives a ring output through an arm/ring/snooze state machine with bounded ring and snooze durations.

## Interface

- RING_SECS, 60, seconds of ringing before auto-stop (1..511)
- SNOOZE_SECS, 300, seconds of silence per snooze (1..511)
- MAX_SNOOZE, 3, snoozes allowed per alarm event (0..3)

- clk  in  1  system clock; one clock domain, all logic on its rising edge
- reset  in  1  synchronous, active-high
- sec_tick  in  1  one-cycle pulse per second (seconds-stage carry)
- hr_t, hr_o, mn_t, mn_o  in  4 each  current time digits, BCD
- alarm_en  in  1  level; alarm switch
- set_load  in  1  pulse; load set_hr_t/set_hr_o/set_mn_t/set_mn_o
- set_hr_t, set_hr_o, set_mn_t, set_mn_o  in  4 each  new alarm digits, BCD
- stop  in  1  pulse; silence alarm
- snooze  in  1  pulse; request snooze
- ring  out  1  buzzer drive
- armed  out  1  state != DISARMED
- state_o  out  2  current state encoding
- snooze_left  out  2  MAX_SNOOZE minus snoozes used this event
- set_err  out  1  one-cycle pulse on rejected set_load

## Operation

- States: DISARMED=0, ARMED=1, RINGING=2, SNOOZING=3.
- match = all four current digits equal stored alarm digits; match_q registers match every cycle in every state. Trigger condition: match & ~match_q. A trigger fires only in ARMED.
- The per-cycle priority order, highest first:
  - reset: all outputs 0, state DISARMED, alarm regs 00:00, counters 0, match_q 0.
  - alarm_en low: go to DISARMED, clear sec counter and snooze count.
  - set_load, valid: load regs. If not DISARMED, go to ARMED and clear counters.
  - set_load, invalid: regs unchanged, set_err=1, state unchanged.
  - A set is valid when hr_t≤2, hr_o≤9 (≤3 if hr_t=2), mn_t≤5, mn_o≤9.
  - stop in RINGING/SNOOZING: go to ARMED, clear sec counter and snooze count.
  - snooze in RINGING with used<MAX_SNOOZE: go to SNOOZING, used++, clear sec counter. Otherwise snooze is ignored.
  - sec_tick in RINGING: counter++. When the counter reaches RING_SECS, go to ARMED and clear counters.
  - sec_tick in SNOOZING: counter++. When the counter reaches SNOOZE_SECS, go to RINGING and clear the counter.
  - ARMED and trigger: go to RINGING, counter 0, used 0.
- DISARMED with alarm_en high: go to ARMED. Entering ARMED during the matching minute does not fire, because the trigger needs an edge.
- After stop or auto-stop, the alarm does not re-ring in the same minute (no edge).
- ring = (state==RINGING), registered.
- Sec counter is 9 bits unsigned, saturating; it is compared with ==.

## Timing

- ring rises 1 cycle after the first cycle where match & ~match_q holds in ARMED.
- stop/snooze/set_load/alarm_en effects are visible on outputs 1 cycle after the input cycle.
- Ring duration is exactly RING_SECS sec_ticks counted after entry. A tick coincident with the entry cycle is not counted.
- Snooze duration is exactly SNOOZE_SECS sec_ticks after entry, under the same rule.
- If snooze and sec_tick coincide, snooze wins and the tick is not counted.
- If stop and snooze coincide, stop wins.
- Reset mid-ring drops ring on the next cycle; the alarm time is lost (00:00).

## Structure

- Shared package alarm_pkg: state enum/localparams, BCD digit limits, 9-bit counter width constant.
- One sub-module alarm_sec_timer: tick counter with clear, enable, and terminal-count compare.
- The FSM, BCD validation, and match logic stay in alarm_ctrl.

## Test plan

- Set alarm 07:30, alarm_en=1, drive time 07:29→07:30 → ring=1 one cycle after the digits change. After 60 sec_ticks, ring=0 and state=ARMED. It does not re-ring while the time stays 07:30.
- Ringing, snooze pulse → state=3, ring=0, snooze_left=2. After 300 ticks, ring=1. Snooze 3 times → snooze_left=0. A 4th snooze is ignored (ring stays 1).
- Ringing, stop and snooze in the same cycle → ARMED, ring=0, snooze_left=3.
- set_load 24:00, then 12:60 → set_err pulses each time, regs unchanged. Load 23:59 → accepted, no set_err.
- alarm_en low while SNOOZING → DISARMED. Raise alarm_en at 07:30 → ARMED, no ring.
- Reset asserted mid-ring → next cycle ring=0, armed=0, state_o=0, snooze_left=0. Time 00:00 with alarm_en=1 → ARMED; changing 23:59→00:00 fires.
